// File: rtl/pipo_shift_reg_if.sv
// Control and status bundle for the universal shift register.
// The master side drives op and operands, and the slave side returns contents and status.
interface pipo_shift_reg_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic             ser_in;
  logic [CNT_W-1:0] cnt_in;
  logic [WIDTH-1:0] data_out;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output op, data_in, ser_in, cnt_in,
    input  data_out, ser_out, busy, done
  );

  modport slave (
    input  op, data_in, ser_in, cnt_in,
    output data_out, ser_out, busy, done
  );
endinterface

// File: rtl/pipo_shift_reg.sv
// Universal datapath register: load, clear, single shifts and auto-sequenced ASR.
// All state updates happen on the falling edge of clk. Every output is registered.
module pipo_shift_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  pipo_shift_reg_if.slave  bus
);
  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_CLR  = 3'b010,
    OP_ASR  = 3'b011,
    OP_LSR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_AUTO = 3'b110,
    OP_RSVD = 3'b111
  } op_t;

  logic [WIDTH-1:0] data_q;
  logic             ser_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] remaining_q;
  logic [WIDTH-1:0] asr_val;
  op_t              op_cur;

  assign asr_val = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
  assign op_cur  = op_t'(bus.op);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      ser_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        // Only CLR can interrupt an auto-shift. It aborts without a done pulse.
        if (op_cur == OP_CLR) begin
          data_q      <= '0;
          ser_q       <= 1'b0;
          busy_q      <= 1'b0;
          remaining_q <= '0;
        end else begin
          data_q      <= asr_val;
          ser_q       <= data_q[0];
          remaining_q <= remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
      end else begin
        case (op_cur)
          OP_LOAD: begin
            data_q <= bus.data_in;
            ser_q  <= 1'b0;
          end
          OP_CLR: begin
            data_q <= '0;
            ser_q  <= 1'b0;
          end
          OP_ASR: begin
            data_q <= asr_val;
            ser_q  <= data_q[0];
          end
          OP_LSR: begin
            data_q <= {bus.ser_in, data_q[WIDTH-1:1]};
            ser_q  <= data_q[0];
          end
          OP_SHL: begin
            data_q <= {data_q[WIDTH-2:0], bus.ser_in};
            ser_q  <= data_q[WIDTH-1];
          end
          OP_AUTO: begin
            // The first step runs on the start edge, so only cnt_in-1 steps remain after it.
            if (bus.cnt_in == '0) begin
              done_q <= 1'b1;
            end else begin
              data_q      <= asr_val;
              ser_q       <= data_q[0];
              remaining_q <= bus.cnt_in - 1'b1;
              busy_q      <= (bus.cnt_in > CNT_W'(1));
              done_q      <= (bus.cnt_in == CNT_W'(1));
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.ser_out  = ser_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_pipo_shift_reg.sv
// Directed bench for pipo_shift_reg, with expected values worked out by hand.
// Inputs change and outputs are sampled 1 time unit after each falling edge.
module tb_pipo_shift_reg;
  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   edges;

  pipo_shift_reg_if #(.WIDTH(16), .CNT_W(5)) bus ();

  pipo_shift_reg #(.WIDTH(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] d, input logic s, input logic [4:0] c);
    bus.op      = op;
    bus.data_in = d;
    bus.ser_in  = s;
    bus.cnt_in  = c;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(3'b000, 16'h0, 1'b0, 5'd0);
    #2;
    chk("rst_data", 32'(bus.data_out), 32'h0);
    chk("rst_ser",  32'(bus.ser_out),  32'h0);
    chk("rst_busy", 32'(bus.busy),     32'h0);
    chk("rst_done", 32'(bus.done),     32'h0);
    rst_n = 1'b1;

    drive(3'b001, 16'hA5C3, 1'b0, 5'd0); tick();
    chk("load_data", 32'(bus.data_out), 32'hA5C3);
    chk("load_ser",  32'(bus.ser_out),  32'h0);

    drive(3'b001, 16'h8004, 1'b0, 5'd0); tick();
    drive(3'b011, 16'h0, 1'b0, 5'd0); tick();
    chk("asr1_data", 32'(bus.data_out), 32'hC002);
    chk("asr1_ser",  32'(bus.ser_out),  32'h0);
    tick();
    chk("asr2_data", 32'(bus.data_out), 32'hE001);
    chk("asr2_ser",  32'(bus.ser_out),  32'h0);
    tick();
    chk("asr3_data", 32'(bus.data_out), 32'hF000);
    chk("asr3_ser",  32'(bus.ser_out),  32'h1);

    drive(3'b001, 16'h8001, 1'b0, 5'd0); tick();
    drive(3'b101, 16'h0, 1'b1, 5'd0); tick();
    chk("shl_data", 32'(bus.data_out), 32'h0003);
    chk("shl_ser",  32'(bus.ser_out),  32'h1);
    drive(3'b100, 16'h0, 1'b1, 5'd0); tick();
    chk("lsr_data", 32'(bus.data_out), 32'h8001);
    chk("lsr_ser",  32'(bus.ser_out),  32'h1);
    drive(3'b100, 16'h0, 1'b0, 5'd0); tick();
    chk("lsr0_data", 32'(bus.data_out), 32'h4000);
    drive(3'b111, 16'hFFFF, 1'b1, 5'd0); tick();
    chk("rsvd_data", 32'(bus.data_out), 32'h4000);
    chk("rsvd_ser",  32'(bus.ser_out),  32'h1);

    // AUTO of 3 steps on F000
    drive(3'b001, 16'hF000, 1'b0, 5'd0); tick();
    drive(3'b110, 16'h0, 1'b0, 5'd3); tick();
    chk("auto3_e0_data", 32'(bus.data_out), 32'hF800);
    chk("auto3_e0_busy", 32'(bus.busy), 32'h1);
    chk("auto3_e0_done", 32'(bus.done), 32'h0);
    drive(3'b000, 16'h0, 1'b0, 5'd0); tick();
    chk("auto3_e1_data", 32'(bus.data_out), 32'hFC00);
    chk("auto3_e1_busy", 32'(bus.busy), 32'h1);
    chk("auto3_e1_done", 32'(bus.done), 32'h0);
    tick();
    chk("auto3_e2_data", 32'(bus.data_out), 32'hFE00);
    chk("auto3_e2_busy", 32'(bus.busy), 32'h0);
    chk("auto3_e2_done", 32'(bus.done), 32'h1);
    tick();
    chk("auto3_post_data", 32'(bus.data_out), 32'hFE00);
    chk("auto3_post_done", 32'(bus.done), 32'h0);

    drive(3'b110, 16'h0, 1'b0, 5'd0); tick();
    chk("auto0_data", 32'(bus.data_out), 32'hFE00);
    chk("auto0_done", 32'(bus.done), 32'h1);
    chk("auto0_busy", 32'(bus.busy), 32'h0);

    // A cnt=1 start, then a restart in the same cycle that done is high.
    drive(3'b110, 16'h0, 1'b0, 5'd1); tick();
    chk("auto1_data", 32'(bus.data_out), 32'hFF00);
    chk("auto1_done", 32'(bus.done), 32'h1);
    chk("auto1_busy", 32'(bus.busy), 32'h0);
    drive(3'b110, 16'h0, 1'b0, 5'd2); tick();
    chk("b2b_e0_data", 32'(bus.data_out), 32'hFF80);
    chk("b2b_e0_busy", 32'(bus.busy), 32'h1);
    chk("b2b_e0_done", 32'(bus.done), 32'h0);
    drive(3'b000, 16'h0, 1'b0, 5'd0); tick();
    chk("b2b_e1_data", 32'(bus.data_out), 32'hFFC0);
    chk("b2b_e1_done", 32'(bus.done), 32'h1);

    // While busy, LOAD is ignored and CLR aborts.
    drive(3'b001, 16'h4000, 1'b0, 5'd0); tick();
    drive(3'b110, 16'h0, 1'b0, 5'd20); tick();
    chk("a20_e0_data", 32'(bus.data_out), 32'h2000);
    chk("a20_e0_busy", 32'(bus.busy), 32'h1);
    drive(3'b001, 16'h1234, 1'b0, 5'd0); tick();
    chk("busy_load_ign", 32'(bus.data_out), 32'h1000);
    chk("busy_load_busy", 32'(bus.busy), 32'h1);
    drive(3'b010, 16'h0, 1'b0, 5'd0); tick();
    chk("abort_data", 32'(bus.data_out), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    drive(3'b000, 16'h0, 1'b0, 5'd0); tick();
    chk("abort_nodone", 32'(bus.done), 32'h0);

    // The maximum count saturates 8000 to FFFF. The edge budget bounds the wait.
    drive(3'b001, 16'h8000, 1'b0, 5'd0); tick();
    drive(3'b110, 16'h0, 1'b0, 5'd31); tick();
    drive(3'b000, 16'h0, 1'b0, 5'd0);
    edges = 1;
    while (!bus.done && edges < 40) begin
      tick();
      edges++;
    end
    chk("sat_edges", 32'(edges), 32'd31);
    chk("sat_data",  32'(bus.data_out), 32'hFFFF);
    chk("sat_ser",   32'(bus.ser_out), 32'h1);

    drive(3'b001, 16'h7FFF, 1'b0, 5'd0); tick();
    drive(3'b110, 16'h0, 1'b0, 5'd20); tick();
    drive(3'b000, 16'h0, 1'b0, 5'd0);
    repeat (19) tick();
    chk("sat0_data", 32'(bus.data_out), 32'h0000);
    chk("sat0_done", 32'(bus.done), 32'h1);

    // An asynchronous reset in the middle of an AUTO sequence.
    drive(3'b001, 16'hF000, 1'b0, 5'd0); tick();
    drive(3'b110, 16'h0, 1'b0, 5'd20); tick();
    drive(3'b000, 16'h0, 1'b0, 5'd0); tick();
    chk("pre_rst_busy", 32'(bus.busy), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(bus.data_out), 32'h0);
    chk("arst_ser",  32'(bus.ser_out), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_done", 32'(bus.done), 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_data", 32'(bus.data_out), 32'h0);
    chk("post_rst_busy", 32'(bus.busy), 32'h0);
    chk("post_rst_done", 32'(bus.done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
